// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file access controller.
package regfile_pkg;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   localparam int NREGS_DEFAULT = 32;
   localparam int AW            = 32;
   localparam int DW            = 32;
   localparam int ERR_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_CAPTURE,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic          op;
      logic [AW-1:0] addr_a;
      logic [AW-1:0] addr_b;
      logic [AW-1:0] addr_wr;
      logic [DW-1:0] wdata;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // True when the address names a real register.
   function automatic logic addr_ok(input logic [AW-1:0] addr, input int nregs);
      return addr < AW'(nregs);
   endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Command and response handshakes between the datapath and the controller.
interface regfile_access_ctrl_if;
   import regfile_pkg::*;

   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_op;
   logic [AW-1:0] cmd_addr_a;
   logic [AW-1:0] cmd_addr_b;
   logic [AW-1:0] cmd_addr_wr;
   logic [DW-1:0] cmd_wdata;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data_a;
   logic [DW-1:0] rsp_data_b;
   logic          rsp_err;

   // Datapath side: issues commands, consumes responses.
   modport master (
      output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_wr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
   );

   // Controller side.
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_wr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
   );

endinterface

// File: rtl/regfile_access_ctrl_cmd_fifo.sv
// Small synchronous command FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module cmd_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   // Storage, pointers and occupancy; a push into a full FIFO is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences buffered write / dual-read commands onto the register-file
// port and returns read results over a valid/ready handshake.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   regfile_access_ctrl_if.slave bus,
   output logic [ERR_W-1:0] err_count,
   output logic [AW-1:0]    rf_addrA,
   output logic [AW-1:0]    rf_addrB,
   output logic [AW-1:0]    rf_addrWR,
   output logic [DW-1:0]    rf_write_data,
   output logic             rf_memwrite,
   output logic             rf_memread,
   input  logic [DW-1:0]    rf_read_dataA,
   input  logic [DW-1:0]    rf_read_dataB
);

   state_e           state_q;
   cmd_t             push_cmd, head;
   logic             fifo_full, fifo_empty, pop;
   logic             wr_ok, rd_ok, head_bad;
   logic             rd_err_q;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // The rf_* registers double as the command register: they capture the
   // popped command and hold it until the next command replaces it.
   logic [AW-1:0]    rf_addrA_q, rf_addrB_q, rf_addrWR_q;
   logic [DW-1:0]    rf_wdata_q;
   logic             rf_memwrite_q, rf_memread_q;

   logic             rsp_valid_q, rsp_err_q;
   logic [DW-1:0]    rsp_data_a_q, rsp_data_b_q;

   assign push_cmd = '{op:      bus.cmd_op,
                       addr_a:  bus.cmd_addr_a,
                       addr_b:  bus.cmd_addr_b,
                       addr_wr: bus.cmd_addr_wr,
                       wdata:   bus.cmd_wdata};

   // Ready depends only on occupancy, so a same-cycle pop never raises it.
   assign bus.cmd_ready = !fifo_full;

   cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.cmd_valid),
      .din_i   (push_cmd),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign pop      = (state_q == ST_IDLE) && !fifo_empty;
   assign wr_ok    = addr_ok(head.addr_wr, NREGS);
   assign rd_ok    = addr_ok(head.addr_a, NREGS) && addr_ok(head.addr_b, NREGS);
   assign head_bad = (head.op == OP_WRITE) ? !wr_ok : !rd_ok;

   // Saturating count of commands rejected for an out-of-range address.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (pop && head_bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
   end

   // Command sequencer; every port-facing output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rd_err_q      <= 1'b0;
         err_cnt_q     <= '0;
         rf_addrA_q    <= '0;
         rf_addrB_q    <= '0;
         rf_addrWR_q   <= '0;
         rf_wdata_q    <= '0;
         rf_memwrite_q <= 1'b0;
         rf_memread_q  <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_data_a_q  <= '0;
         rsp_data_b_q  <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         unique case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  if (head.op == OP_WRITE) begin
                     rf_addrWR_q   <= head.addr_wr;
                     rf_wdata_q    <= head.wdata;
                     rf_memwrite_q <= wr_ok;
                     state_q       <= ST_WRITE;
                  end else begin
                     rf_addrA_q    <= head.addr_a;
                     rf_addrB_q    <= head.addr_b;
                     rf_memread_q  <= rd_ok;
                     rd_err_q      <= !rd_ok;
                     state_q       <= ST_READ;
                  end
               end
            end
            ST_WRITE: begin
               rf_memwrite_q <= 1'b0;
               state_q       <= ST_IDLE;
            end
            ST_READ: begin
               rf_memread_q <= 1'b0;
               state_q      <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // Register file data is valid this cycle (one after memread).
               rsp_data_a_q <= rd_err_q ? '0 : rf_read_dataA;
               rsp_data_b_q <= rd_err_q ? '0 : rf_read_dataB;
               rsp_err_q    <= rd_err_q;
               rsp_valid_q  <= 1'b1;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rf_addrA       = rf_addrA_q;
   assign rf_addrB       = rf_addrB_q;
   assign rf_addrWR      = rf_addrWR_q;
   assign rf_write_data  = rf_wdata_q;
   assign rf_memwrite    = rf_memwrite_q;
   assign rf_memread     = rf_memread_q;
   assign err_count      = err_cnt_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data_a = rsp_data_a_q;
   assign bus.rsp_data_b = rsp_data_b_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule
